// File: rtl/fp_addsub_seq_pkg.sv
// Shared constants for the FPU add/sub execution unit: opcodes, IEEE-754
// single-precision field widths and special values, and the FSM state codes.
package fpu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 23;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 2 * BIAS + 1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_UNPACK = 3'd1;
    localparam logic [2:0] ST_ALIGN  = 3'd2;
    localparam logic [2:0] ST_ADD    = 3'd3;
    localparam logic [2:0] ST_NORM   = 3'd4;
    localparam logic [2:0] ST_ROUND  = 3'd5;

endpackage

// File: rtl/fp_addsub_seq_if.sv
// Operand/opcode request and result bundle between the FPU front end
// (master) and the add/sub execution unit (slave).
interface fp_addsub_seq_if;
    import fpu_pkg::*;

    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic [1:0]  opcode;
    logic        busy;
    logic        done;
    logic [31:0] O;
    logic        invalid;
    logic        overflow;

    modport master (
        output start, A, B, opcode,
        input  busy, done, O, invalid, overflow
    );

    modport slave (
        input  start, A, B, opcode,
        output busy, done, O, invalid, overflow
    );

endinterface

// File: rtl/fp_addsub_seq_lzc.sv
// 28-bit combinational leading-zero counter; an all-zero input yields 28.
module fp_lzc (
    input  logic [27:0] in_val,
    output logic [4:0]  lz_cnt
);

    logic found;

    always_comb begin
        lz_cnt = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < 28; i++) begin
            if (!found) begin
                if (in_val[27 - i]) begin
                    found = 1'b1;
                end else begin
                    lz_cnt = lz_cnt + 5'd1;
                end
            end
        end
    end

endmodule

// File: rtl/fp_addsub_seq.sv
// Multi-cycle single-precision add/sub: IDLE -> UNPACK -> ALIGN -> ADD -> NORM
// -> ROUND, round-to-nearest-even, denormals flushed to signed zero.
module fp_addsub_seq
    import fpu_pkg::*;
#(
    parameter int unsigned LATENCY = 5,
    parameter int unsigned FTZ     = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    fp_addsub_seq_if.slave bus
);

    if (FTZ != 1 || LATENCY != 5) begin : g_cfg_check
        $error("fp_addsub_seq: only FTZ=1 and LATENCY=5 are implemented");
    end

    logic [2:0]        state_q, state_d;
    logic [31:0]       a_q, a_d, b_q, b_d;
    logic [1:0]        op_q, op_d;
    logic              sx_q, sx_d, sy_q, sy_d;
    logic [EXP_W-1:0]  ex_q, ex_d, ey_q, ey_d;
    logic [FRAC_W:0]   mx_q, mx_d, my_q, my_d;
    logic              spec_q, spec_d, spec_inv_q, spec_inv_d;
    logic [31:0]       spec_res_q, spec_res_d;
    logic [26:0]       mxa_q, mxa_d, mya_q, mya_d;
    logic              sub_q, sub_d;
    logic [27:0]       sum_q, sum_d;
    logic [26:0]       nm_q, nm_d;
    logic [9:0]        ne_q, ne_d;
    logic              nzero_q, nzero_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic [31:0]       o_q, o_d;
    logic              inv_q, inv_d, ovf_q, ovf_d;

    logic [EXP_W-1:0]  ea, eb, big_e, sml_e, diff;
    logic [FRAC_W-1:0] fa, fb;
    logic              sa, sb, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, bad_op;
    logic              swap, big_s, sml_s, y_lost, round_up;
    logic [FRAC_W:0]   big_m, sml_m, rmant;
    logic [26:0]       y_field, y_shift;
    logic [27:0]       norm_sh;
    logic [24:0]       mr;
    logic [9:0]        e_r;
    logic [FRAC_W-1:0] frac_r;
    logic [4:0]        lz;

    fp_lzc u_lzc (
        .in_val (sum_q),
        .lz_cnt (lz)
    );

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        sx_d       = sx_q;
        sy_d       = sy_q;
        ex_d       = ex_q;
        ey_d       = ey_q;
        mx_d       = mx_q;
        my_d       = my_q;
        spec_d     = spec_q;
        spec_inv_d = spec_inv_q;
        spec_res_d = spec_res_q;
        mxa_d      = mxa_q;
        mya_d      = mya_q;
        sub_d      = sub_q;
        sum_d      = sum_q;
        nm_d       = nm_q;
        ne_d       = ne_q;
        nzero_d    = nzero_q;
        done_d     = 1'b0;
        o_d        = o_q;
        inv_d      = inv_q;
        ovf_d      = ovf_q;

        ea = a_q[30:23];  fa = a_q[22:0];  sa = a_q[31];
        eb = b_q[30:23];  fb = b_q[22:0];  sb = b_q[31] ^ (op_q == OP_SUB);
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        a_inf  = (ea == '1) && (fa == '0);
        b_inf  = (eb == '1) && (fb == '0);
        a_nan  = (ea == '1) && (fa != '0);
        b_nan  = (eb == '1) && (fb != '0);
        bad_op = (op_q != OP_ADD) && (op_q != OP_SUB);

        swap   = (ey_q > ex_q) || ((ey_q == ex_q) && (my_q > mx_q));
        big_s  = swap ? sy_q : sx_q;
        sml_s  = swap ? sx_q : sy_q;
        big_e  = swap ? ey_q : ex_q;
        sml_e  = swap ? ex_q : ey_q;
        big_m  = swap ? my_q : mx_q;
        sml_m  = swap ? mx_q : my_q;
        diff   = big_e - sml_e;
        y_field = {sml_m, 3'b000};
        y_shift = y_field >> diff;
        y_lost  = |(y_field & ~({27{1'b1}} << diff));

        norm_sh  = sum_q << (lz - 5'd1);
        rmant    = nm_q[26:3];
        round_up = nm_q[2] & (nm_q[1] | nm_q[0] | rmant[0]);
        mr       = {1'b0, rmant} + {24'd0, round_up};
        e_r      = ne_q + {9'd0, mr[24]};
        frac_r   = mr[24] ? mr[23:1] : mr[22:0];

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    op_d    = bus.opcode;
                    inv_d   = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = ST_UNPACK;
                end
            end
            ST_UNPACK: begin
                sx_d       = sa;
                sy_d       = sb;
                ex_d       = ea;
                ey_d       = eb;
                mx_d       = {1'b1, fa};
                my_d       = {1'b1, fb};
                spec_d     = 1'b1;
                spec_inv_d = 1'b0;
                spec_res_d = '0;
                if (bad_op || a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
                    spec_res_d = QNAN;
                    spec_inv_d = 1'b1;
                end else if (a_inf) begin
                    spec_res_d = {sa, POS_INF[30:0]};
                end else if (b_inf) begin
                    spec_res_d = {sb, POS_INF[30:0]};
                end else if (a_zero && b_zero) begin
                    spec_res_d = {sa & sb, 31'd0};
                end else if (a_zero) begin
                    spec_res_d = {sb, b_q[30:0]};
                end else if (b_zero) begin
                    spec_res_d = {sa, a_q[30:0]};
                end else begin
                    spec_d = 1'b0;
                end
                state_d = ST_ALIGN;
            end
            ST_ALIGN: begin
                sx_d  = big_s;
                ex_d  = big_e;
                sub_d = big_s ^ sml_s;
                mxa_d = {big_m, 3'b000};
                // Shifts of 27 or more leave only the sticky bit of a nonzero Y.
                mya_d = (diff >= 8'd27) ? 27'd1 : {y_shift[26:1], y_shift[0] | y_lost};
                state_d = ST_ADD;
            end
            ST_ADD: begin
                sum_d   = sub_q ? ({1'b0, mxa_q} - {1'b0, mya_q})
                                : ({1'b0, mxa_q} + {1'b0, mya_q});
                state_d = ST_NORM;
            end
            ST_NORM: begin
                nzero_d = 1'b0;
                if (sum_q == '0) begin
                    nzero_d = 1'b1;
                    sx_d    = 1'b0;
                end else if (sum_q[27]) begin
                    nm_d = {sum_q[27:2], sum_q[1] | sum_q[0]};
                    ne_d = {2'b00, ex_q} + 10'd1;
                end else begin
                    // Leading one lands on bit 26, so the exponent drops by lz-1.
                    nm_d = norm_sh[26:0];
                    ne_d = {2'b00, ex_q} + 10'd1 - {5'd0, lz};
                    if (ne_d[9] || (ne_d == '0)) begin
                        nzero_d = 1'b1;
                    end
                end
                state_d = ST_ROUND;
            end
            ST_ROUND: begin
                inv_d = 1'b0;
                ovf_d = 1'b0;
                if (spec_q) begin
                    o_d   = spec_res_q;
                    inv_d = spec_inv_q;
                end else if (nzero_q) begin
                    o_d = {sx_q, 31'd0};
                end else if (e_r >= 10'(EXP_MAX)) begin
                    o_d   = {sx_q, POS_INF[30:0]};
                    ovf_d = 1'b1;
                end else begin
                    o_d = {sx_q, e_r[7:0], frac_r};
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_ALIGN) || (state_d == ST_ADD) ||
                 (state_d == ST_NORM)  || (state_d == ST_ROUND);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            sx_q       <= 1'b0;
            sy_q       <= 1'b0;
            ex_q       <= '0;
            ey_q       <= '0;
            mx_q       <= '0;
            my_q       <= '0;
            spec_q     <= 1'b0;
            spec_inv_q <= 1'b0;
            spec_res_q <= '0;
            mxa_q      <= '0;
            mya_q      <= '0;
            sub_q      <= 1'b0;
            sum_q      <= '0;
            nm_q       <= '0;
            ne_q       <= '0;
            nzero_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            o_q        <= '0;
            inv_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            sx_q       <= sx_d;
            sy_q       <= sy_d;
            ex_q       <= ex_d;
            ey_q       <= ey_d;
            mx_q       <= mx_d;
            my_q       <= my_d;
            spec_q     <= spec_d;
            spec_inv_q <= spec_inv_d;
            spec_res_q <= spec_res_d;
            mxa_q      <= mxa_d;
            mya_q      <= mya_d;
            sub_q      <= sub_d;
            sum_q      <= sum_d;
            nm_q       <= nm_d;
            ne_q       <= ne_d;
            nzero_q    <= nzero_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            o_q        <= o_d;
            inv_q      <= inv_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.O        = o_q;
    assign bus.invalid  = inv_q;
    assign bus.overflow = ovf_q;

endmodule
